// File: rtl/sm83_bus_pkg.sv
// +----------------------------------------------------------------------+
// | sm83_bus_pkg : shared types and default decode bounds for the SM83   |
// |                memory-bus sequencer and its address decoder.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sm83_bus_pkg;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_phase_t;

  typedef enum logic [1:0] {
    ROM = 2'd0,
    CS  = 2'd1,
    INT = 2'd2
  } bus_region_t;

  localparam logic [15:0] HI_BASE_DEF = 16'hFE00;
  localparam logic [15:0] CS_LO_DEF   = 16'hA000;

endpackage

`default_nettype wire

// File: rtl/sm83_bus_decode.sv
// +----------------------------------------------------------------------+
// | sm83_bus_decode : combinational address to bus-region decode.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sm83_bus_decode
  import sm83_bus_pkg::*;
#(
  parameter logic [15:0] HI_BASE = HI_BASE_DEF,
  parameter logic [15:0] CS_LO   = CS_LO_DEF
) (
  input  logic [15:0] addr,
  output bus_region_t region
);

  always_comb begin
    region = ROM;
    if (addr >= HI_BASE) begin
      region = INT;
    end else if (addr >= CS_LO) begin
      region = CS;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm83_bus_seq.sv
// +----------------------------------------------------------------------+
// | sm83_bus_seq : 4-T-state M-cycle bus sequencer with high-page        |
// |                routing to the internal bus.                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sm83_bus_seq
  import sm83_bus_pkg::*;
#(
  parameter logic [15:0] HI_BASE = HI_BASE_DEF,
  parameter logic [15:0] CS_LO   = CS_LO_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] apin,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [7:0]  dout,
  input  logic        stall,
  input  logic [7:0]  d_pin_in,
  input  logic [7:0]  int_din,
  output logic [1:0]  t_phase,
  output logic [15:0] a_pin,
  output logic        rd_n,
  output logic        wr_n,
  output logic        cs_n,
  output logic [7:0]  d_pin_out,
  output logic        d_oe,
  output logic        int_sel,
  output logic        int_wr,
  output logic [7:0]  din,
  output logic        rd_done
);

  localparam logic [1:0] c_PH_T1 = 2'd0;
  localparam logic [1:0] c_PH_T2 = 2'd1;
  localparam logic [1:0] c_PH_T3 = 2'd2;
  localparam logic [1:0] c_PH_T4 = 2'd3;

  bus_region_t w_region;
  logic        w_req;
  logic        w_rd;
  logic        w_int;
  logic        w_cs;

  logic        r_active;
  logic        r_write;
  logic        r_int;

  sm83_bus_decode #(
    .HI_BASE (HI_BASE),
    .CS_LO   (CS_LO)
  ) u_decode (
    .addr   (apin),
    .region (w_region)
  );

  // Write has priority; a simultaneous read request is discarded.
  assign w_req = mem_rd | mem_wr;
  assign w_rd  = mem_rd & ~mem_wr;
  assign w_int = (w_region == INT);
  assign w_cs  = (w_region == CS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_phase   <= c_PH_T1;
      a_pin     <= 16'h0000;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      cs_n      <= 1'b1;
      d_pin_out <= 8'h00;
      d_oe      <= 1'b0;
      int_sel   <= 1'b0;
      int_wr    <= 1'b0;
      din       <= 8'h00;
      rd_done   <= 1'b0;
      r_active  <= 1'b0;
      r_write   <= 1'b0;
      r_int     <= 1'b0;
    end else if (stall) begin
      // rd_done is a strict single-clock pulse, so it alone is not held.
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (t_phase)
        c_PH_T4: begin
          t_phase <= c_PH_T1;
          if (r_active && !r_write) begin
            din     <= r_int ? int_din : d_pin_in;
            rd_done <= 1'b1;
          end
          r_active <= w_req;
          r_write  <= mem_wr;
          r_int    <= w_int;
          int_sel  <= w_req & w_int;
          rd_n     <= ~(w_rd & ~w_int);
          cs_n     <= ~(w_req & w_cs);
          wr_n     <= 1'b1;
          d_oe     <= 1'b0;
          int_wr   <= 1'b0;
          if (w_req && !w_int) begin
            a_pin <= apin;
          end
          if (mem_wr && !w_int) begin
            d_pin_out <= dout;
          end
        end
        c_PH_T1: begin
          t_phase <= c_PH_T2;
          if (r_active && r_write) begin
            if (r_int) begin
              int_wr <= 1'b1;
            end else begin
              wr_n <= 1'b0;
              d_oe <= 1'b1;
            end
          end
        end
        c_PH_T2: begin
          t_phase <= c_PH_T3;
        end
        default: begin
          // Entering T4: write strobes end, d_oe holds through T4.
          t_phase <= c_PH_T4;
          wr_n    <= 1'b1;
          int_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm83_bus_seq.sv
// +----------------------------------------------------------------------+
// | tb_sm83_bus_seq : directed and random checks of sm83_bus_seq against |
// |                   a transaction-level model.                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sm83_bus_seq;

  logic        clk;
  logic        reset;
  logic [15:0] apin;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  dout;
  logic        stall;
  logic [7:0]  d_pin_in;
  logic [7:0]  int_din;
  logic [1:0]  t_phase;
  logic [15:0] a_pin;
  logic        rd_n;
  logic        wr_n;
  logic        cs_n;
  logic [7:0]  d_pin_out;
  logic        d_oe;
  logic        int_sel;
  logic        int_wr;
  logic [7:0]  din;
  logic        rd_done;

  sm83_bus_seq dut (
    .clk       (clk),
    .reset     (reset),
    .apin      (apin),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .dout      (dout),
    .stall     (stall),
    .d_pin_in  (d_pin_in),
    .int_din   (int_din),
    .t_phase   (t_phase),
    .a_pin     (a_pin),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .cs_n      (cs_n),
    .d_pin_out (d_pin_out),
    .d_oe      (d_oe),
    .int_sel   (int_sel),
    .int_wr    (int_wr),
    .din       (din),
    .rd_done   (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: the access in flight plus the T-state index.
  int          m_ph;
  bit          m_valid;
  bit          m_wr;
  int          m_reg;     // 0 ROM, 1 CS, 2 internal
  logic [15:0] m_alast;
  logic [7:0]  m_dpo;
  logic [7:0]  m_din;
  bit          m_done;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [15:0] a);
    if (a >= 16'hFE00) return 2;
    if (a >= 16'hA000) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_valid = 0; m_wr = 0; m_reg = 0;
    m_alast = 16'h0000; m_dpo = 8'h00; m_din = 8'h00; m_done = 0;
  endtask

  task automatic compare_all();
    bit ext;
    bit wwin;
    ext  = m_valid && (m_reg != 2);
    wwin = (m_ph == 1) || (m_ph == 2);
    chk_eq("t_phase", t_phase, m_ph);
    chk_eq("a_pin", a_pin, m_alast);
    chk_eq("rd_n", rd_n, !(ext && !m_wr));
    chk_eq("cs_n", cs_n, !(m_valid && m_reg == 1));
    chk_eq("wr_n", wr_n, !(ext && m_wr && wwin));
    chk_eq("d_oe", d_oe, ext && m_wr && m_ph >= 1);
    chk_eq("int_sel", int_sel, m_valid && m_reg == 2);
    chk_eq("int_wr", int_wr, m_valid && m_reg == 2 && m_wr && wwin);
    chk_eq("din", din, m_din);
    chk_eq("rd_done", rd_done, m_done);
    if (ext && m_wr && m_ph >= 1) chk_eq("d_pin_out", d_pin_out, m_dpo);
  endtask

  task automatic step(input bit st, input bit rd, input bit wr, input logic [15:0] a,
                      input logic [7:0] d, input logic [7:0] dpin, input logic [7:0] idin);
    stall = st; mem_rd = rd; mem_wr = wr; apin = a; dout = d;
    d_pin_in = dpin; int_din = idin;
    @(posedge clk);
    if (st) begin
      m_done = 0;
    end else if (m_ph == 3) begin
      m_done = m_valid && !m_wr;
      if (m_done) m_din = (m_reg == 2) ? idin : dpin;
      m_valid = rd || wr;
      m_wr    = wr;
      m_reg   = region_of(a);
      if (m_valid && m_reg != 2) m_alast = a;
      if (wr && m_reg != 2) m_dpo = d;
      m_ph = 0;
    end else begin
      m_ph++;
      m_done = 0;
    end
    #1;
    compare_all();
  endtask

  // Idle up to the T4 edge, then present the request on that edge.
  task automatic mcyc(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d,
                      input logic [7:0] dpin, input logic [7:0] idin);
    for (int k = 0; k < 4 && m_ph != 3; k++) step(0, 0, 0, 16'h0000, 8'h00, dpin, idin);
    step(0, rd, wr, a, d, dpin, idin);
  endtask

  // Reset pulled mid-cycle, away from any clock edge.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    compare_all();
  endtask

  logic [15:0] bnd [8] = '{16'h0000, 16'h9FFF, 16'hA000, 16'hC000,
                           16'hFDFF, 16'hFE00, 16'hFF44, 16'hFFFF};

  initial begin
    reset = 1'b0; stall = 0; mem_rd = 0; mem_wr = 0; apin = 0; dout = 0;
    d_pin_in = 0; int_din = 0;
    model_reset();
    #12;
    compare_all();
    reset = 1'b1;

    // ROM read, CS write, internal read, read+write collision.
    mcyc(1, 0, 16'h0150, 8'h00, 8'h11, 8'h22);
    mcyc(0, 1, 16'hC000, 8'hA5, 8'h3C, 8'h77);
    mcyc(1, 0, 16'hFF44, 8'h00, 8'h55, 8'h66);
    mcyc(1, 1, 16'hD000, 8'h5A, 8'h12, 8'h90);

    // Requests held only across the T2 edge must be ignored.
    for (int k = 0; k < 4 && m_ph != 1; k++) step(0, 0, 0, 16'h0000, 8'h00, 8'h01, 8'h02);
    step(0, 1, 1, 16'h1234, 8'hEE, 8'h01, 8'h02);
    mcyc(0, 0, 16'h0000, 8'h00, 8'h03, 8'h04);

    // Write stalled five clocks in T2.
    mcyc(0, 1, 16'hC123, 8'h3E, 8'h05, 8'h06);
    step(0, 0, 0, 16'h0000, 8'h00, 8'h07, 8'h08);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 16'h4000, 8'h00, 8'h09, 8'h0A);
    mcyc(0, 0, 16'h0000, 8'h00, 8'h0B, 8'h0C);

    // Reset during T3 of a CS read.
    mcyc(1, 0, 16'hA100, 8'h00, 8'h0D, 8'h0E);
    step(0, 0, 0, 16'h0000, 8'h00, 8'h0F, 8'h10);
    step(0, 0, 0, 16'h0000, 8'h00, 8'h0F, 8'h10);
    mid_reset();
    for (int k = 0; k < 8; k++) step(0, 0, 0, 16'h0000, 8'h00, 8'h5F, 8'h6F);

    // Random traffic with stalls and region boundaries.
    for (int n = 0; n < 800; n++) begin
      logic [15:0] a;
      logic [31:0] r;
      r = $urandom;
      a = (r[1:0] == 2'd0) ? bnd[r[4:2]] : r[31:16];
      step(($urandom_range(0, 7) == 0), r[5], r[6], a, r[15:8],
           8'($urandom), 8'($urandom));
      if (n == 400) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
